// File: rtl/i2c_cmd_queue.sv
// ---------------------------------------------------------------------------
// i2c_cmd_queue
//
// This is the upstream command stage for the i2c master. It buffers
// {addr, data, rw} transactions in a small FIFO. It issues them to the master
// one at a time, so software and fabric can push commands without knowing
// anything about bus timing.
//
// Optional feature: define I2C_CMDQ_TIMEOUT_EN to enable a watchdog. The
// watchdog aborts a transaction after TIMEOUT cycles in WAIT_ACC or
// WAIT_DONE. With the macro undefined, the FSM waits indefinitely and the
// timeout output is tied 0.
//
// Parameters
//   DEPTH         FIFO entries (power of 2, 2..16)
//   AW            log2(DEPTH); cmd_count is AW+1 bits wide
//   START_CYCLES  cycles i2c_start is held per transaction (1..15)
//   TIMEOUT       watchdog limit in cycles (used only with the macro)
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   cmd_push        write {cmd_addr, cmd_data, cmd_rw} into the FIFO
//   cmd_full        FIFO holds DEPTH entries
//   cmd_count       queued entries, excluding the in-flight command
//   cmd_ovf         1-cycle pulse: a push was dropped because FIFO was full
//   i2c_ready       master idle (high) / busy (low)
//   i2c_start       start request to the master
//   i2c_addr/data/rw  command presented to the master; changes only on pop
//   busy            FSM not in IDLE
//   done            1-cycle pulse: the master returned ready
//   timeout         1-cycle pulse: watchdog abort
// ---------------------------------------------------------------------------
module i2c_cmd_queue #(
  parameter int DEPTH        = 4,
  parameter int AW           = 2,
  parameter int START_CYCLES = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_push,
  input  logic [6:0]  cmd_addr,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_rw,
  output logic        cmd_full,
  output logic [AW:0] cmd_count,
  output logic        cmd_ovf,
  input  logic        i2c_ready,
  output logic        i2c_start,
  output logic [6:0]  i2c_addr,
  output logic [7:0]  i2c_data,
  output logic        i2c_rw,
  output logic        busy,
  output logic        done,
  output logic        timeout
);

  if ((DEPTH != (1 << AW)) || (DEPTH < 2) || (DEPTH > 16) ||
      (START_CYCLES < 1) || (START_CYCLES > 15) || (TIMEOUT < 1)) begin : g_param_check
    $error("i2c_cmd_queue: illegal parameter combination");
  end

  localparam logic [AW:0] LP_FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [3:0]  LP_START_END = 4'(START_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_ACC  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next;

  logic [15:0]    r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic           r_ovf;
  logic [6:0]     r_addr;
  logic [7:0]     r_data;
  logic           r_rw;
  logic [3:0]     r_scnt;
  logic           r_fell;

  logic           w_full;
  logic           w_push_ok;
  logic           w_pop;
  logic [15:0]    w_head;
  logic           w_tmo_hit;

  // Full is judged on the registered count, so a push into a full FIFO is
  // dropped even when a pop happens in the same cycle.
  assign w_full    = (r_count == LP_FULL_CNT);
  assign w_push_ok = cmd_push && !w_full;
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0) && i2c_ready;
  assign w_head    = r_mem[r_rptr];

  // FIFO storage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= {cmd_addr, cmd_data, cmd_rw};
    end
  end

  // FIFO control: pointers wrap naturally at DEPTH = 2**AW
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= cmd_push && w_full;
      if (w_push_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Command registers toward the master: load on pop, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_data <= '0;
      r_rw   <= 1'b0;
    end else if (w_pop) begin
      r_addr <= w_head[15:9];
      r_data <= w_head[8:1];
      r_rw   <= w_head[0];
    end
  end

  // ISSUE phase: start-length counter and a sticky flag that remembers the
  // master going busy while i2c_start is still held.
  always_ff @(posedge clk) begin
    if (rst || (r_state != S_ISSUE)) begin
      r_scnt <= '0;
      r_fell <= 1'b0;
    end else begin
      r_scnt <= r_scnt + 1'b1;
      if (!i2c_ready) begin
        r_fell <= 1'b1;
      end
    end
  end

`ifdef I2C_CMDQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LP_TMO = TW'(TIMEOUT);

  logic [TW-1:0] r_tcnt;

  // Watchdog counts cycles spent in the current wait state; it restarts
  // from zero on every state change.
  always_ff @(posedge clk) begin
    if (rst || (r_state != w_next) ||
        !((r_state == S_WAIT_ACC) || (r_state == S_WAIT_DONE))) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign w_tmo_hit = (r_tcnt == LP_TMO);
`else
  assign w_tmo_hit = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // If the master already went busy during start, skip WAIT_ACC.
        if (r_scnt == LP_START_END) begin
          w_next = (r_fell || !i2c_ready) ? S_WAIT_DONE : S_WAIT_ACC;
        end
      end
      S_WAIT_ACC: begin
        if (!i2c_ready) begin
          w_next = S_WAIT_DONE;
        end else if (w_tmo_hit) begin
          w_next = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (i2c_ready) begin
          w_next = S_IDLE;
        end else if (w_tmo_hit) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    i2c_start = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    timeout   = 1'b0;
    case (r_state)
      S_IDLE:      busy = 1'b0;
      S_ISSUE:     i2c_start = 1'b1;
      S_WAIT_ACC:  timeout = i2c_ready && w_tmo_hit;
      S_WAIT_DONE: begin
        done    = i2c_ready;
        timeout = !i2c_ready && w_tmo_hit;
      end
      default:     busy = 1'b0;
    endcase
  end

  assign cmd_full  = w_full;
  assign cmd_count = r_count;
  assign cmd_ovf   = r_ovf;
  assign i2c_addr  = r_addr;
  assign i2c_data  = r_data;
  assign i2c_rw    = r_rw;

endmodule
